// File: rtl/vga_tile_reader_pkg.sv
// Shared types, colours and default 640x480@60 timing for the snake VGA path.
// GRID_OVERLAY_EN (optional) selects the grid colour path in vga_tile_reader.
package snake_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BODY  = 2'd1,
        HEAD  = 2'd2,
        FOOD  = 2'd3
    } tile_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    typedef struct packed {
        logic vis;
        logic hs;
        logic vs;
        logic first;
    } pix_s1_t;

    localparam rgb_t COL_EMPTY = 12'h000;
    localparam rgb_t COL_BODY  = 12'h0F0;
    localparam rgb_t COL_HEAD  = 12'hFF0;
    localparam rgb_t COL_FOOD  = 12'hF00;
    localparam rgb_t COL_GRID  = 12'h333;

    localparam int DEF_H_VIS  = 640;
    localparam int DEF_H_FP   = 16;
    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BP   = 48;
    localparam int DEF_V_VIS  = 480;
    localparam int DEF_V_FP   = 10;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP   = 33;

    function automatic rgb_t tile_color(tile_t t);
        rgb_t c;
        c = COL_EMPTY;
        unique case (t)
            EMPTY: c = COL_EMPTY;
            BODY:  c = COL_BODY;
            HEAD:  c = COL_HEAD;
            FOOD:  c = COL_FOOD;
        endcase
        return c;
    endfunction

    // Constant k folds this into a pure shift-add tree.
    function automatic logic [31:0] mul_const(logic [31:0] a, int unsigned k);
        logic [31:0] acc;
        acc = '0;
        for (int i = 0; i < 32; i++) begin
            if (k[i]) acc = acc + (a << i);
        end
        return acc;
    endfunction

endpackage

// File: rtl/vga_tile_reader_if.sv
// Tile RAM read port plus VGA pin bundle for vga_tile_reader.
interface vga_tile_reader_if #(
    parameter int ADDR_W = 11
);
    logic [ADDR_W-1:0] ram_addr;
    logic [1:0]        ram_rdata;
    logic              hsync;
    logic              vsync;
    logic [3:0]        red;
    logic [3:0]        green;
    logic [3:0]        blue;
    logic              frame_start;

    modport master (
        output ram_addr, hsync, vsync, red, green, blue, frame_start,
        input  ram_rdata
    );

    modport slave (
        input  ram_addr, hsync, vsync, red, green, blue, frame_start,
        output ram_rdata
    );
endinterface

// File: rtl/vga_tile_reader_timing.sv
// vga_timing: pixel/line counters with visible flag and raw active-low syncs.
module vga_timing
    import snake_pkg::*;
#(
    parameter int H_VIS  = DEF_H_VIS,
    parameter int H_FP   = DEF_H_FP,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP   = DEF_H_BP,
    parameter int V_VIS  = DEF_V_VIS,
    parameter int V_FP   = DEF_V_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP   = DEF_V_BP,
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP,
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP,
    localparam int HW    = $clog2(H_TOT),
    localparam int VW    = $clog2(V_TOT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pix_en,
    output logic [HW-1:0] hcnt,
    output logic [VW-1:0] vcnt,
    output logic          vis,
    output logic          hs_raw,
    output logic          vs_raw
);

    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;

    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (pix_en) begin
            if (hcnt_q == HW'(H_TOT - 1)) begin
                hcnt_d = '0;
                if (vcnt_q == VW'(V_TOT - 1)) vcnt_d = '0;
                else vcnt_d = vcnt_q + VW'(1);
            end else begin
                hcnt_d = hcnt_q + HW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    assign hcnt   = hcnt_q;
    assign vcnt   = vcnt_q;
    assign vis    = (hcnt_q < HW'(H_VIS)) && (vcnt_q < VW'(V_VIS));
    assign hs_raw = !((hcnt_q >= HW'(H_VIS + H_FP)) &&
                      (hcnt_q <  HW'(H_VIS + H_FP + H_SYNC)));
    assign vs_raw = !((vcnt_q >= VW'(V_VIS + V_FP)) &&
                      (vcnt_q <  VW'(V_VIS + V_FP + V_SYNC)));

endmodule

// File: rtl/vga_tile_reader.sv
// Streams tile-RAM contents as 640x480 VGA through a 2-tick video pipeline.
// Optional macro GRID_OVERLAY_EN draws a gray grid over empty tiles.
module vga_tile_reader
    import snake_pkg::*;
#(
    parameter int H_VIS      = DEF_H_VIS,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_VIS      = DEF_V_VIS,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter int TILE_SHIFT = 4,
    parameter int ADDR_W     = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_en,
    vga_tile_reader_if.master  bus
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int unsigned TPR = H_VIS >> TILE_SHIFT;

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          vis;
    logic          hs_raw;
    logic          vs_raw;

    vga_timing #(
        .H_VIS (H_VIS),  .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_VIS (V_VIS),  .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_timing (
        .clk    (clk),
        .reset  (reset),
        .pix_en (pix_en),
        .hcnt   (hcnt),
        .vcnt   (vcnt),
        .vis    (vis),
        .hs_raw (hs_raw),
        .vs_raw (vs_raw)
    );

    logic [ADDR_W-1:0] addr_c;
    assign addr_c = ADDR_W'(mul_const(32'(vcnt >> TILE_SHIFT), TPR)
                            + 32'(hcnt >> TILE_SHIFT));

    pix_s1_t           s1_q, s1_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              hsync_q, hsync_d;
    logic              vsync_q, vsync_d;
    rgb_t              rgb_q, rgb_d;
    logic              frame_start_q, frame_start_d;

`ifdef GRID_OVERLAY_EN
    logic grid_q, grid_d;
    logic grid_c;
    assign grid_c = (hcnt[TILE_SHIFT-1:0] == '0) ||
                    (vcnt[TILE_SHIFT-1:0] == '0);
`endif

    always_comb begin
        s1_d          = s1_q;
        ram_addr_d    = ram_addr_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        rgb_d         = rgb_q;
        frame_start_d = 1'b0;
`ifdef GRID_OVERLAY_EN
        grid_d        = grid_q;
`endif
        if (pix_en) begin
            s1_d.vis   = vis;
            s1_d.hs    = hs_raw;
            s1_d.vs    = vs_raw;
            s1_d.first = (hcnt == '0) && (vcnt == '0);
            // Off-screen the address freezes so the RAM port stays quiet.
            if (vis) ram_addr_d = addr_c;
            hsync_d       = s1_q.hs;
            vsync_d       = s1_q.vs;
            rgb_d         = s1_q.vis ? tile_color(tile_t'(bus.ram_rdata))
                                     : COL_EMPTY;
            frame_start_d = s1_q.first;
`ifdef GRID_OVERLAY_EN
            grid_d = grid_c;
            if (s1_q.vis && grid_q && (tile_t'(bus.ram_rdata) == EMPTY))
                rgb_d = COL_GRID;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_q          <= '{vis: 1'b0, hs: 1'b1, vs: 1'b1, first: 1'b0};
            ram_addr_q    <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            rgb_q         <= COL_EMPTY;
            frame_start_q <= 1'b0;
`ifdef GRID_OVERLAY_EN
            grid_q        <= 1'b0;
`endif
        end else begin
            s1_q          <= s1_d;
            ram_addr_q    <= ram_addr_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            rgb_q         <= rgb_d;
            frame_start_q <= frame_start_d;
`ifdef GRID_OVERLAY_EN
            grid_q        <= grid_d;
`endif
        end
    end

    assign bus.ram_addr    = ram_addr_q;
    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.red         = rgb_q.r;
    assign bus.green       = rgb_q.g;
    assign bus.blue        = rgb_q.b;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_tile_reader.sv
// Bench for vga_tile_reader on a shrunk raster (40x30 tiles of 2 px) with a
// position-based reference model driven by randomized pix_en spacing.
module tb_vga_tile_reader;

    localparam int HV = 80;
    localparam int HF = 4;
    localparam int HS = 8;
    localparam int HB = 4;
    localparam int VV = 60;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int TS = 1;
    localparam int AW = 11;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int TSZ = 1 << TS;
    localparam int TPR = HV / TSZ;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic pix_en = 1'b0;
    always #5 clk = ~clk;

    vga_tile_reader_if #(.ADDR_W(AW)) bus ();

    logic [1:0] mem [0:2047];
    always @(posedge clk) bus.ram_rdata <= mem[bus.ram_addr];

    vga_tile_reader #(
        .H_VIS (HV), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_VIS (VV), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .TILE_SHIFT (TS), .ADDR_W (AW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .pix_en (pix_en),
        .bus    (bus)
    );

    int n_chk = 0;
    int n_fail = 0;
    int t, exp_addr, last_fs, hs_cnt, vs_cnt;
    logic exp_hs, exp_vs;
    logic [11:0] exp_rgb;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (tick %0d)", tag, got, exp, t);
        end
    endtask

    function automatic logic [11:0] tile_rgb(int ty, int h, int v);
        logic [11:0] c;
        case (ty)
            1: c = 12'h0F0;
            2: c = 12'hFF0;
            3: c = 12'hF00;
            default: c = 12'h000;
        endcase
`ifdef GRID_OVERLAY_EN
        if (ty == 0 && (h % TSZ == 0 || v % TSZ == 0)) c = 12'h333;
`endif
        return c;
    endfunction

    function automatic int addr_of(int h, int v);
        return (v / TSZ) * TPR + h / TSZ;
    endfunction

    task automatic do_reset(int n);
        reset = 1'b0;
        for (int i = 0; i < n; i++) begin
            pix_en = (i % 2 == 0);
            @(posedge clk);
            #1;
            chk("rst_hsync", bus.hsync, 1);
            chk("rst_vsync", bus.vsync, 1);
            chk("rst_rgb", {bus.red, bus.green, bus.blue}, 0);
            chk("rst_addr", bus.ram_addr, 0);
            chk("rst_fs", bus.frame_start, 0);
        end
        pix_en = 1'b0;
        reset = 1'b1;
        t = 0;
        exp_addr = 0;
        last_fs = -1;
        hs_cnt = 0;
        vs_cnt = 0;
    endtask

    task automatic tick();
        int p, h, v, q, qh, qv, gap;
        logic vis;
        p = 0; h = 0; v = 0;
        pix_en = 1'b1;
        @(posedge clk);
        #1;
        pix_en = 1'b0;
        t++;
        q = (t - 1) % FRAME;
        qh = q % HT;
        qv = q / HT;
        if (qh < HV && qv < VV) exp_addr = addr_of(qh, qv);
        if (t >= 2) begin
            p = (t - 2) % FRAME;
            h = p % HT;
            v = p / HT;
            vis = (h < HV) && (v < VV);
            exp_hs = !(h >= HV + HF && h < HV + HF + HS);
            exp_vs = !(v >= VV + VF && v < VV + VF + VS);
            exp_rgb = vis ? tile_rgb(int'(mem[addr_of(h, v)]), h, v) : 12'h000;
        end else begin
            exp_hs = 1'b1;
            exp_vs = 1'b1;
            exp_rgb = 12'h000;
        end
        chk("hsync", bus.hsync, exp_hs);
        chk("vsync", bus.vsync, exp_vs);
        chk("rgb", {bus.red, bus.green, bus.blue}, exp_rgb);
        chk("frame_start", bus.frame_start, (t >= 2 && p == 0));
        chk("ram_addr", bus.ram_addr, exp_addr);
        if (qh == 37 && qv == 50) chk("addr_37_50", bus.ram_addr, 1018);
        if (qh == HV - 1 && qv == VV - 1) chk("addr_last", bus.ram_addr, 1199);
        if (!bus.hsync) hs_cnt++;
        if (!bus.vsync) vs_cnt++;
        if (t >= 2 && h == HT - 1) begin
            chk("hs_width", hs_cnt, HS);
            hs_cnt = 0;
        end
        if (t >= 2 && p == FRAME - 1) begin
            chk("vs_width", vs_cnt, VS * HT);
            vs_cnt = 0;
        end
        if (bus.frame_start) begin
            if (last_fs < 0) chk("fs_first", t, 2);
            else chk("fs_period", t - last_fs, FRAME);
            last_fs = t;
        end
        gap = $urandom_range(1, 2);
        @(posedge clk);
        #1;
        chk("fs_pulse", bus.frame_start, 0);
        chk("hold_hsync", bus.hsync, exp_hs);
        chk("hold_rgb", {bus.red, bus.green, bus.blue}, exp_rgb);
        repeat (gap - 1) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        foreach (mem[i]) mem[i] = 2'($urandom);
        t = 0;
        do_reset(5);
        repeat (FRAME + 10) tick();
        repeat (20 * HT + 37) tick();
        foreach (mem[i]) mem[i] = 2'd0;
        mem[1018] = 2'd2;
        mem[1199] = 2'd3;
        do_reset(4);
        repeat (FRAME + 4) tick();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
